// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier result path: product and
// display widths plus the state encoding of the binary-to-BCD converter.
package booth_pkg;

    localparam int W_PROD     = 16;
    localparam int BCD_DIGITS = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } bcd_state_t;

endpackage : booth_pkg

// File: rtl/booth_result_bcd_if.sv
// Bundle between the multiplier side (product/done) and the BCD converter
// outputs that feed the decimal display.
interface booth_result_bcd_if
    import booth_pkg::*;
#(
    parameter int W  = W_PROD,
    parameter int ND = BCD_DIGITS
);
    logic [W-1:0]    product;
    logic            done;
    logic            sign;
    logic [4*ND-1:0] bcd;
    logic            busy;
    logic            valid;

    // Multiplier / stimulus side: supplies the product, watches the result.
    modport master (
        output product,
        output done,
        input  sign,
        input  bcd,
        input  busy,
        input  valid
    );

    // Converter side.
    modport slave (
        input  product,
        input  done,
        output sign,
        output bcd,
        output busy,
        output valid
    );
endinterface : booth_result_bcd_if

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of double-dabble: a digit of 5 or more is
// pre-biased by 3 so the following left shift carries into the next digit.
module bcd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    // Add-3 correction for digits >= 5.
    always_comb begin
        if (d_i >= 4'd5) begin
            d_o = d_i + 4'd3;
        end else begin
            d_o = d_i;
        end
    end

endmodule : bcd_digit_adj

// File: rtl/booth_result_bcd.sv
// Signed product to sign + packed BCD converter. A rising edge of the
// multiplier's done flag captures the product; its magnitude is shifted
// through a double-dabble loop (one bit per cycle) and the result is
// published, and then held, in the output registers.
module booth_result_bcd
    import booth_pkg::*;
#(
    parameter int W  = W_PROD,
    parameter int ND = BCD_DIGITS
) (
    input  logic               clk,
    input  logic               rst,
    booth_result_bcd_if.slave  bus
);

    localparam int            CW       = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    bcd_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    mag_q, mag_d;
    logic [4*ND-1:0] scratch_q, scratch_d;
    logic            sign_cap_q, sign_cap_d;
    logic            sign_q, sign_d;
    logic [4*ND-1:0] bcd_q, bcd_d;
    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;

    logic            start_s;
    logic [4*ND-1:0] adj_s;

    // Per-digit add-3 correction applied to the scratch register.
    for (genvar i = 0; i < ND; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (scratch_q[4*i +: 4]),
            .d_o (adj_s[4*i +: 4])
        );
    end

    assign start_s = bus.done & ~done_q;

    // Next-state logic: edge detect, capture, shift loop and result publish.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mag_d      = mag_q;
        scratch_d  = scratch_q;
        sign_cap_d = sign_cap_q;
        sign_d     = sign_q;
        bcd_d      = bcd_q;
        busy_d     = busy_q;
        valid_d    = valid_q;
        done_d     = bus.done;

        case (state_q)
            IDLE: begin
                if (start_s) begin
                    // Unsigned W-bit negate: the most negative value maps to 2^(W-1).
                    sign_cap_d = bus.product[W-1];
                    if (bus.product[W-1]) begin
                        mag_d = ~bus.product + {{(W-1){1'b0}}, 1'b1};
                    end else begin
                        mag_d = bus.product;
                    end
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                    valid_d   = 1'b0;
                    busy_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                {scratch_d, mag_d} = {adj_s[4*ND-2:0], mag_q, 1'b0};
                cnt_d              = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FINISH;
                end else begin
                    state_d = SHIFT;
                end
            end
            FINISH: begin
                bcd_d   = scratch_q;
                sign_d  = sign_cap_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mag_q      <= '0;
            scratch_q  <= '0;
            sign_cap_q <= 1'b0;
            sign_q     <= 1'b0;
            bcd_q      <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mag_q      <= mag_d;
            scratch_q  <= scratch_d;
            sign_cap_q <= sign_cap_d;
            sign_q     <= sign_d;
            bcd_q      <= bcd_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    assign bus.sign  = sign_q;
    assign bus.bcd   = bcd_q;
    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;

endmodule : booth_result_bcd

// File: tb/tb_booth_result_bcd.sv
// Directed bench for booth_result_bcd: hand-computed vectors, latency,
// output holding, ignored start while busy and reset abort.
module tb_booth_result_bcd;

    logic clk;
    logic rst;

    int checks;
    int errors;
    int cyc;
    logic        prev_sign;
    logic [19:0] prev_bcd;

    booth_result_bcd_if #(.W(16), .ND(5)) bus ();

    booth_result_bcd #(.W(16), .ND(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Request a conversion; returns just after edge k (cyc = 0).
    task automatic start_conv(input logic [15:0] p);
        @(negedge clk);
        bus.product = p;
        bus.done    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.done = 1'b0;
        cyc      = 0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("valid_low_busy", 32'(bus.valid), 32'd0);
        check("bcd_held", 32'(bus.bcd), 32'(prev_bcd));
        check("sign_held", 32'(bus.sign), 32'(prev_sign));
    endtask

    task automatic step_cycle();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Wait (bounded) for valid and check latency and result.
    task automatic finish_conv(input logic s, input logic [19:0] b);
        while (bus.valid !== 1'b1 && cyc < 40) begin
            step_cycle();
        end
        check("latency", 32'(cyc), 32'd17);
        check("busy_done", 32'(bus.busy), 32'd0);
        check("valid_done", 32'(bus.valid), 32'd1);
        check("sign", 32'(bus.sign), 32'(s));
        check("bcd", 32'(bus.bcd), 32'(b));
        prev_sign = s;
        prev_bcd  = b;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        prev_sign   = 1'b0;
        prev_bcd    = 20'h00000;
        rst         = 1'b1;
        bus.done    = 1'b0;
        bus.product = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_sign", 32'(bus.sign), 32'd0);
        check("rst_bcd", 32'(bus.bcd), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);

        // Basic vectors.
        start_conv(16'h0006); finish_conv(1'b0, 20'h00006);
        start_conv(16'hC080); finish_conv(1'b1, 20'h16256);
        start_conv(16'h4000); finish_conv(1'b0, 20'h16384);
        start_conv(16'h8000); finish_conv(1'b1, 20'h32768);
        start_conv(16'h0000); finish_conv(1'b0, 20'h00000);

        // Start while busy is ignored; product change after capture is ignored.
        start_conv(16'h0006);
        repeat (4) step_cycle();
        bus.product = 16'h1234;
        bus.done    = 1'b1;
        finish_conv(1'b0, 20'h00006);
        for (int i = 0; i < 20; i++) begin
            step_cycle();
            check("held_valid", 32'(bus.valid), 32'd1);
            check("held_busy", 32'(bus.busy), 32'd0);
        end
        check("held_bcd", 32'(bus.bcd), 32'h00006);
        bus.done = 1'b0;
        step_cycle();

        // Reset in the middle of a conversion.
        start_conv(16'hC080);
        repeat (7) step_cycle();
        rst      = 1'b1;
        bus.done = 1'b1;
        step_cycle();
        check("abort_sign", 32'(bus.sign), 32'd0);
        check("abort_bcd", 32'(bus.bcd), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_valid", 32'(bus.valid), 32'd0);
        step_cycle();
        rst = 1'b0;
        // done held high through release: one conversion on the first cycle.
        step_cycle();
        cyc = 0;
        check("rel_busy", 32'(bus.busy), 32'd1);
        check("rel_valid", 32'(bus.valid), 32'd0);
        finish_conv(1'b1, 20'h16256);
        repeat (5) step_cycle();
        check("rel_no_retrigger", 32'(bus.busy), 32'd0);
        bus.done = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_booth_result_bcd

// File: doc/booth_result_bcd.md
# booth_result_bcd

Sequential signed-binary-to-BCD converter sitting directly downstream of the 8-bit Booth multiplier. It watches the multiplier's completion flag, captures the 16-bit two's-complement product, and converts its magnitude to packed BCD with a separate sign bit using a shift-and-add-3 (double-dabble) loop. The results drive the board's decimal display logic. The BCD result is held until the next product completes.

## Interface
- `W`, default 16: product width in bits (two's complement).
- `ND`, default 5: number of BCD digits. Must satisfy 10^ND > 2^(W-1).
- `clk`  in  1: single system clock; all state changes on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `product`  in  W: multiplier `Answer`; sampled only on the start cycle.
- `done`  in  1: multiplier `Over` (level). A 0→1 transition requests a conversion.
- `sign`  out  1: 1 when the captured product was negative.
- `bcd`  out  4*ND: packed BCD magnitude; digit 0 is in bits [3:0].
- `busy`  out  1: conversion in progress.
- `valid`  out  1: `sign`/`bcd` hold a completed conversion.

## Operation
- Edge detect: `done_q` is `done` registered every cycle. `start = done & ~done_q`.
- The FSM has states IDLE, SHIFT and FINISH.
- **IDLE, on start:**
  - Capture `sign = product[W-1]`.
  - Capture `mag = product[W-1] ? -product : product` as unsigned W bits, so that 0x8000 gives 32768.
  - Clear the scratch BCD register and set `cnt = 0`.
  - Go to SHIFT. `valid` drops to 0 and `busy` rises to 1.
- **SHIFT, each cycle:**
  - Every scratch digit ≥5 gets +3.
  - Then shift {scratch, mag} left by 1 and increment `cnt`.
  - After the W-th shift (`cnt == W-1` at the edge), go to FINISH.
- **FINISH:** copy scratch to `bcd` and the captured sign to `sign`. Set `valid = 1`, `busy = 0`, then return to IDLE.
- **Output holding:** `sign` and `bcd` change only in FINISH. Outputs keep their old values while `busy` is high, but `valid` is 0 during that time.
- **Zero:** a product of 0 gives `sign = 0` and `bcd = 0`. Negative zero cannot occur.
- **start while busy:** ignored and not queued. `done_q` keeps tracking, so a level held high does not retrigger afterward.

## Timing
- Reset values: `sign = 0`, `bcd = 0`, `busy = 0`, `valid = 0`, `done_q = 0`, state IDLE, `cnt = 0`.
- Because `done_q` resets to 0, a `done` held high through reset release triggers one conversion on the first post-reset cycle.
- Let edge k be the edge where `start` is sampled true:
  - `busy` is 1 from edge k through edge k+W+1.
  - SHIFT occupies edges k+1 to k+W.
  - At edge k+W+1, `bcd`, `sign` and `valid = 1` appear and `busy` returns to 0.
  - Latency is W+1 = 17 cycles.
- A new start is accepted at the earliest on edge k+W+2, after the return to IDLE.
- Throughput is one conversion per W+2 cycles.
- `rst` asserted mid-conversion aborts at that edge: all reset values are restored and the partial result is discarded.
- `product` may change at any time except the start cycle. Only the start-cycle value is used.

## Structure
- Shared package `booth_pkg` holds:
  - `W_PROD = 16` and `BCD_DIGITS = 5`.
  - The FSM state enum `bcd_state_t` {IDLE, SHIFT, FINISH}.
- Sub-module `bcd_digit_adj`: combinational, 4-bit in/out, outputs d+3 when d≥5, else d. It is instantiated ND times in a generate loop.
- Top-level RTL holds:
  - the edge detector, FSM and counter (width clog2(W)),
  - the capture and magnitude negate,
  - the scratch and shift registers,
  - the output registers.

## Test plan
- Drive `product = 0x0006` (-3 × -2 from the multiplier) and pulse `done` → after 17 cycles, `sign = 0`, `bcd = 0x00006`, `valid = 1`, `busy = 0`.
- Drive `product = 0xC080` (-16256 = -128 × 127) → `sign = 1`, `bcd = 0x16256`. Drive 0x4000 (-128 × -128) → `sign = 0`, `bcd = 0x16384`.
- Drive `product = 0x8000` → `sign = 1`, `bcd = 0x32768`. Drive 0x0000 → `sign = 0`, `bcd = 0x00000`.
- Start 0x0006, change `product` to 0x1234 and toggle `done` 0→1 at cycle 5 of busy → the result is still 0x00006 with no second conversion. `done` held high afterward → `valid` stays 1 and `busy` stays 0.
- Complete 0x00006, start 0xC080, then assert `rst` at cycle 8 of busy → the next cycle has all outputs 0 and state IDLE. Release reset with `done` high → one conversion of the current `product`, result valid 17 cycles later.
